// File: rtl/basic_io_port.sv
// -----------------------------------------------------------------------------
// basic_io_port
//
// Terminal I/O port for the basic computer's INPR/FGI and OUTR/FGO path.
//
// Input side: an external byte stream (rx_data/rx_valid/rx_ready) fills a small
// FIFO. Whenever the CPU-visible input flag fgi is clear and the FIFO holds a
// byte, the head byte is moved into inpr and fgi is set on the following edge.
// An INP instruction (inp_ack) clears fgi; inpr keeps its value.
//
// Output side: an OUT instruction (out_stb) while fgo=1 loads outr into
// tx_data, raises tx_valid and clears fgo. The byte leaves on the
// tx_valid/tx_ready handshake, which also sets fgo again. An out_stb while
// fgo=0 is discarded and sets the sticky out_drop flag.
//
// Handshake semantics (both rx and tx streams): a transfer happens on a rising
// clk edge where valid && ready are both high. The sender holds data stable and
// keeps valid high until that edge; valid never drops without a transfer.
//
// Optional feature, macro BASIC_IO_IRQ_EN:
//   defined   : irq is registered, irq <= ien && (fgi || fgo) every edge.
//   undefined : irq is tied to 0 and ien is ignored (CPU polls SKI/SKO).
//
// Parameters:
//   IN_DEPTH  input FIFO entries (power of 2, >= 2)
//   PTR_W     log2(IN_DEPTH)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx_data/valid/rdy external input stream (rx_ready = FIFO not full)
//   inpr, fgi         byte and flag presented to the CPU
//   inp_ack           CPU executed INP (1-cycle pulse)
//   outr, out_stb     byte from AC[7:0] and OUT pulse
//   fgo               output flag: ready for a new byte
//   tx_data/valid/rdy external output stream
//   ien, irq          interrupt enable in, interrupt request out
//   in_count          FIFO occupancy, 0..IN_DEPTH
//   out_drop          sticky: out_stb seen while fgo=0
// -----------------------------------------------------------------------------
module basic_io_port #(
  parameter int IN_DEPTH = 4,
  parameter int PTR_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       inpr,
  output logic             fgi,
  input  logic             inp_ack,
  input  logic [7:0]       outr,
  input  logic             out_stb,
  output logic             fgo,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             ien,
  output logic             irq,
  output logic [PTR_W:0]   in_count,
  output logic             out_drop
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(IN_DEPTH);

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [IN_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign rx_ready   = !fifo_full;

  // rx_ready is derived from the registered count only, so a pop in the same
  // cycle never makes room for a push while full.
  assign push = rx_valid && !fifo_full;

  // The head byte moves to inpr only while fgi is low. Because fgi is a
  // register, a freshly pushed byte needs one edge to enter the FIFO and a
  // second edge to reach inpr; there is no rx -> inpr bypass.
  assign pop = !fgi && !fifo_empty;

  // Storage carries no reset: entries are only read after being written,
  // and reset empties the FIFO by clearing the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly PTR_W bits, so they wrap modulo IN_DEPTH.
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or push and pop together
      endcase
    end
  end

  assign in_count = count;

  // ---------------------------------------------------------------------------
  // Input presentation (INPR / FGI)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr <= 8'h00;
      fgi  <= 1'b0;
    end else begin
      if (pop) begin
        // pop implies fgi=0, so inp_ack cannot matter in the same cycle.
        inpr <= mem[rd_ptr];
        fgi  <= 1'b1;
      end else if (inp_ack && fgi) begin
        // inpr deliberately keeps the consumed byte.
        fgi <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output path (OUTR / FGO / tx stream)
  // ---------------------------------------------------------------------------
  logic tx_fire;
  logic out_accept;
  logic out_reject;

  assign tx_fire    = tx_valid && tx_ready;
  // fgo=0 whenever tx_valid=1, so an out_stb during a tx handshake is always
  // a reject, never a new load.
  assign out_accept = out_stb && fgo;
  assign out_reject = out_stb && !fgo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      fgo      <= 1'b1;
      out_drop <= 1'b0;
    end else begin
      if (tx_fire) begin
        // tx_data is left as is after the transfer.
        tx_valid <= 1'b0;
        fgo      <= 1'b1;
      end else if (out_accept) begin
        tx_data  <= outr;
        tx_valid <= 1'b1;
        fgo      <= 1'b0;
      end
      if (out_reject) begin
        out_drop <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt request
  // ---------------------------------------------------------------------------
`ifdef BASIC_IO_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= ien && (fgi || fgo);
    end
  end
`else
  // Polled build: the enable input has no function.
  logic unused_ien;
  assign unused_ien = ien;
  assign irq        = 1'b0;
`endif

endmodule
